// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, legality check and execute-stage occupancy states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_st_t;

    function automatic logic alu_ctrl_legal(input logic [2:0] c);
        return c inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; illegal codes yield a zero result with the illegal flag set.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    logic slt;

    always_comb begin
        slt     = $signed(SrcA) < $signed(SrcB);
        illegal = !alu_ctrl_legal(ALUControl);
        result  = ALUControl == ALU_ADD ? SrcA + SrcB :
                  ALUControl == ALU_SUB ? SrcA - SrcB :
                  ALUControl == ALU_AND ? SrcA & SrcB :
                  ALUControl == ALU_OR  ? SrcA | SrcB :
                  ALUControl == ALU_SLT ? {{(WIDTH-1){1'b0}}, slt} : '0;
        zero    = result == '0;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute-stage ALU with valid/ready handshakes and a one-entry
// skid buffer so in_ready is a pure register, never combinationally tied to out_ready.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    stage_st_t        state_q, state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] m_res_q, s_res_q, core_res;
    logic             m_zero_q, m_ill_q, s_zero_q, s_ill_q, core_zero, core_ill;
    logic             acc, fire, ld_m, mv_s, ld_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .result     (core_res),
        .zero       (core_zero),
        .illegal    (core_ill)
    );

    always_comb begin
        acc     = in_valid && in_ready_q;
        fire    = state_q != ST_EMPTY && out_ready;
        state_d = state_q;
        ld_m    = 1'b0;
        mv_s    = 1'b0;
        ld_s    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                ld_m    = acc;
                state_d = acc ? ST_ONE : ST_EMPTY;
            end
            ST_ONE: begin
                ld_m    = acc && fire;
                ld_s    = acc && !fire;
                state_d = acc && !fire ? ST_FULL : !acc && fire ? ST_EMPTY : ST_ONE;
            end
            ST_FULL: begin
                mv_s    = fire;
                state_d = fire ? ST_ONE : ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_res_q    <= '0;
            m_zero_q   <= 1'b0;
            m_ill_q    <= 1'b0;
            s_res_q    <= '0;
            s_zero_q   <= 1'b0;
            s_ill_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            // S holding an entry is exactly the condition that blocks input next cycle
            in_ready_q <= state_d != ST_FULL;
            if (ld_m) begin
                m_res_q  <= core_res;
                m_zero_q <= core_zero;
                m_ill_q  <= core_ill;
            end else if (mv_s) begin
                m_res_q  <= s_res_q;
                m_zero_q <= s_zero_q;
                m_ill_q  <= s_ill_q;
            end
            if (ld_s) begin
                s_res_q  <= core_res;
                s_zero_q <= core_zero;
                s_ill_q  <= core_ill;
            end else if (mv_s) begin
                s_res_q  <= '0;
                s_zero_q <= 1'b0;
                s_ill_q  <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = state_q != ST_EMPTY;
    assign ALUResult = m_res_q;
    assign Zero      = m_zero_q;
    assign Illegal   = m_ill_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and random checks of alu_exec_stage against a queue-based
// reference model; inputs change and outputs are sampled on the falling clock edge.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ALUControl = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    int errors = 0;
    int checks = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {result, zero, illegal} straight from the operation definitions
    function automatic logic [33:0] ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        ill = !(c inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
        case (c)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd5:    r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {r, r == 32'd0, ill};
    endfunction

    task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei);
        chk({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1; ALUControl = c; SrcA = a; SrcB = b; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_res"}, ALUResult, er);
        chk({tag, "_zero"}, Zero, ez);
        chk({tag, "_ill"}, Illegal, ei);
        @(negedge clk);
        chk({tag, "_drain"}, out_valid, 0);
    endtask

    // One cycle against the queue model: check, drive, then advance the model past the edge
    task automatic step(input string tag, input bit iv, input bit orr, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b, output bit accepted);
        chk({tag, "_in_ready"}, in_ready, q.size() < 2);
        chk({tag, "_out_valid"}, out_valid, q.size() > 0);
        if (q.size() > 0) chk({tag, "_data"}, {ALUResult, Zero, Illegal}, q[0]);
        in_valid = iv; out_ready = orr; ALUControl = c; SrcA = a; SrcB = b;
        accepted = iv && q.size() < 2;
        if (orr && q.size() > 0) void'(q.pop_front());
        if (accepted) q.push_back(ref_op(c, a, b));
        @(negedge clk);
    endtask

    initial begin
        bit          acc;
        int          issued;
        logic [31:0] a, b;
        logic [2:0]  c;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {ALUResult, Zero, Illegal}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        do_op("sub", 3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("and", 3'b010, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
        do_op("or", 3'b011, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1'b0);
        do_op("slt_neg", 3'b101, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);
        do_op("slt_pos", 3'b101, 32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        do_op("slt_eq", 3'b101, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        do_op("ill100", 3'b100, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
        do_op("ill110", 3'b110, 32'hFFFF, 32'h1, 32'd0, 1'b1, 1'b1);
        do_op("ill111", 3'b111, 32'h7, 32'h7, 32'd0, 1'b1, 1'b1);
        do_op("legal_after_ill", 3'b000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        // Eight back-to-back ADDs with out_ready low for three cycles mid-stream
        issued = 0;
        for (int cyc = 0; cyc < 40 && (issued < 8 || q.size() > 0); cyc++) begin
            step("stream", issued < 8, !(cyc >= 3 && cyc <= 5), 3'b000, 32'(issued * 16), 32'd1, acc);
            if (acc) issued++;
        end
        chk("stream_issued", issued, 8);
        chk("stream_drained", out_valid, 0);

        for (int cyc = 0; cyc < 10000; cyc++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, c, a, b, acc);
        end

        // Fill both registers, then reset asynchronously in the middle of a low clock phase
        step("fill", 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, acc);
        step("fill", 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, acc);
        step("fill", 1'b1, 1'b0, 3'b000, 32'd10, 32'd20, acc);
        step("fill", 1'b1, 1'b0, 3'b001, 32'd10, 32'd20, acc);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, acc);
        step("post_rst", 1'b1, 1'b1, 3'b011, 32'hA0, 32'h0B, acc);
        step("post_rst", 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, acc);
        step("post_rst", 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
